// File: rtl/ac_motor_svpwm_gen_pkg.sv
// Shared constants, sector encodings and sector-to-phase role lookup for the SVPWM generator.
package ac_motor_svpwm_gen_pkg;

  // Valid sector encodings; 0 and 7 are invalid
  localparam logic [2:0] SECTOR_1 = 3'd1;
  localparam logic [2:0] SECTOR_2 = 3'd2;
  localparam logic [2:0] SECTOR_3 = 3'd3;
  localparam logic [2:0] SECTOR_4 = 3'd4;
  localparam logic [2:0] SECTOR_5 = 3'd5;
  localparam logic [2:0] SECTOR_6 = 3'd6;

  // Phase indices into gate_hi / gate_lo
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam int unsigned N_PH = 3;

  // Carrier count direction
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Which phase takes each switching role in a sector; odd selects t1 as the mid increment
  typedef struct packed {
    logic       valid;
    logic       odd;
    logic [1:0] lead;
    logic [1:0] mid;
    logic [1:0] last;
  } sector_roles_t;

  // Half-period length in clock cycles
  function automatic int unsigned calc_t_half(input int unsigned clk_hz, input int unsigned pwm_hz);
    return clk_hz / (2 * pwm_hz);
  endfunction

  function automatic logic sector_valid(input logic [2:0] sector);
    return (sector >= SECTOR_1) && (sector <= SECTOR_6);
  endfunction

  // Role table: lead/mid/last phase for each valid sector
  function automatic sector_roles_t sector_roles(input logic [2:0] sector);
    sector_roles_t r;
    r = '0;
    case (sector)
      SECTOR_1: r = '{valid: 1'b1, odd: 1'b1, lead: PH_A, mid: PH_B, last: PH_C};
      SECTOR_2: r = '{valid: 1'b1, odd: 1'b0, lead: PH_B, mid: PH_A, last: PH_C};
      SECTOR_3: r = '{valid: 1'b1, odd: 1'b1, lead: PH_B, mid: PH_C, last: PH_A};
      SECTOR_4: r = '{valid: 1'b1, odd: 1'b0, lead: PH_C, mid: PH_B, last: PH_A};
      SECTOR_5: r = '{valid: 1'b1, odd: 1'b1, lead: PH_C, mid: PH_A, last: PH_B};
      SECTOR_6: r = '{valid: 1'b1, odd: 1'b0, lead: PH_A, mid: PH_C, last: PH_B};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ac_motor_svpwm_gen_dead_time.sv
// Single-phase dead-time inserter: turns a raw phase command into a complementary gate pair.
module ac_motor_svpwm_gen_dead_time #(
  parameter int unsigned DEADTIME = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic raw,
  output logic gate_hi,
  output logic gate_lo
);

  localparam int unsigned DW = $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] DT_V = DW'(DEADTIME);

  logic          raw_q, raw_d;
  logic [DW-1:0] tmr_q, tmr_d;
  logic          hi_q, hi_d;
  logic          lo_q, lo_d;

  // Any raw edge drops both gates and restarts the timer; the new side turns on when it expires.
  // While disabled the timer is held full so a re-enable also waits a whole dead interval.
  always_comb begin
    raw_d = raw;
    tmr_d = tmr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (!en) begin
      hi_d  = 1'b0;
      lo_d  = 1'b0;
      tmr_d = DT_V;
    end else if (raw != raw_q) begin
      hi_d  = 1'b0;
      lo_d  = 1'b0;
      tmr_d = DT_V;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - DW'(1);
      if (tmr_q == DW'(1)) begin
        hi_d = raw_q;
        lo_d = ~raw_q;
      end
    end
  end

  // State and gate registers
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= 1'b0;
      tmr_q <= DT_V;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      raw_q <= raw_d;
      tmr_q <= tmr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign gate_hi = hi_q;
  assign gate_lo = lo_q;

endmodule

// File: rtl/ac_motor_svpwm_gen.sv
// SVPWM generator: centre-aligned carrier, 3-stage vector-time pipeline with overmodulation
// clamp, valley-loaded shadow registers, sector role mux and per-phase dead time.
module ac_motor_svpwm_gen
  import ac_motor_svpwm_gen_pkg::*;
#(
  parameter  int unsigned W        = 12,
  parameter  int unsigned CLK_HZ   = 100_000_000,
  parameter  int unsigned PWM_HZ   = 5_000,
  parameter  int unsigned DEADTIME = 50,
  localparam int unsigned T_HALF   = calc_t_half(CLK_HZ, PWM_HZ),
  localparam int unsigned TW       = $clog2(T_HALF + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [W-1:0]  u_str,
  input  logic [W-1:0]  sine_pos,
  input  logic [W-1:0]  sine_neg,
  input  logic [2:0]    sector,
  output logic [TW-1:0] t0,
  output logic [TW-1:0] t1,
  output logic [TW-1:0] t2,
  output logic [TW-1:0] t7,
  output logic [2:0]    gate_hi,
  output logic [2:0]    gate_lo,
  output logic          period_start,
  output logic          ovm,
  output logic          sector_fault
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned MW = PW + TW;
  localparam logic [TW-1:0] T_HALF_V = TW'(T_HALF);
  localparam logic [TW:0]   T_HALF_X = (TW + 1)'(T_HALF);

  // ---------------- carrier ----------------
  logic [TW-1:0] cnt_q, cnt_d;
  dir_e          dir_q, dir_d;
  logic          ps_q, ps_d;
  logic          gate_en_q, gate_en_d;
  logic          peak_c;
  logic          valley_next_c;

  // Triangle counter 0..T_HALF..1, valley pulse, and gate enable that re-arms only at a valley
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (dir_q == DIR_UP) begin
      cnt_d = cnt_q + TW'(1);
      if (cnt_d == T_HALF_V) dir_d = DIR_DOWN;
    end else begin
      cnt_d = cnt_q - TW'(1);
      if (cnt_d == '0) dir_d = DIR_UP;
    end
    valley_next_c = (cnt_d == '0);
    peak_c        = (cnt_q == T_HALF_V);
    ps_d          = valley_next_c;
    gate_en_d     = enable && (gate_en_q || (cnt_q == '0));
  end

  // Carrier registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      ps_q      <= 1'b0;
      gate_en_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      ps_q      <= ps_d;
      gate_en_q <= gate_en_d;
    end
  end

  // ---------------- vector-time pipeline ----------------
  logic [PW-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [2:0]    sec_s1_q, sec_s1_d, sec_s2_q, sec_s2_d;
  logic          vld_s1_q, vld_s1_d, vld_s2_q, vld_s2_d;
  logic [TW-1:0] t1r_q, t1r_d, t2r_q, t2r_d;

  // S1 captures products at the peak; S2 scales them to cycles (truncating)
  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    sec_s1_d = sec_s1_q;
    vld_s1_d = peak_c;
    if (peak_c) begin
      p1_d     = PW'(u_str) * PW'(sine_neg);
      p2_d     = PW'(u_str) * PW'(sine_pos);
      sec_s1_d = sector;
    end
    t1r_d    = t1r_q;
    t2r_d    = t2r_q;
    sec_s2_d = sec_s2_q;
    vld_s2_d = vld_s1_q;
    if (vld_s1_q) begin
      t1r_d    = TW'((MW'(p1_q) * MW'(T_HALF)) >> PW);
      t2r_d    = TW'((MW'(p2_q) * MW'(T_HALF)) >> PW);
      sec_s2_d = sec_s1_q;
    end
  end

  // S1/S2 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q     <= '0;
      p2_q     <= '0;
      sec_s1_q <= SECTOR_1;
      vld_s1_q <= 1'b0;
      t1r_q    <= '0;
      t2r_q    <= '0;
      sec_s2_q <= SECTOR_1;
      vld_s2_q <= 1'b0;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      sec_s1_q <= sec_s1_d;
      vld_s1_q <= vld_s1_d;
      t1r_q    <= t1r_d;
      t2r_q    <= t2r_d;
      sec_s2_q <= sec_s2_d;
      vld_s2_q <= vld_s2_d;
    end
  end

  logic [TW:0]   sum_c;
  logic [TW-1:0] t1c_c, t2c_c, rem_c, t0c_c, t7c_c;
  logic          ovmc_c;

  // S3 clamp and zero-vector split; t7 takes the odd cycle
  always_comb begin
    sum_c  = {1'b0, t1r_q} + {1'b0, t2r_q};
    t1c_c  = t1r_q;
    t2c_c  = t2r_q;
    ovmc_c = 1'b0;
    if (t1r_q >= T_HALF_V) begin
      t1c_c  = T_HALF_V;
      t2c_c  = '0;
      ovmc_c = 1'b1;
    end else if (sum_c > T_HALF_X) begin
      t2c_c  = T_HALF_V - t1r_q;
      ovmc_c = 1'b1;
    end
    rem_c = T_HALF_V - t1c_c - t2c_c;
    t0c_c = rem_c >> 1;
    t7c_c = rem_c - t0c_c;
  end

  logic [TW-1:0] sh_t0_q, sh_t0_d, sh_t1_q, sh_t1_d, sh_t2_q, sh_t2_d, sh_t7_q, sh_t7_d;
  logic          sh_ovm_q, sh_ovm_d;
  logic [2:0]    sh_sec_q, sh_sec_d;
  logic [TW-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t7_q, t7_d;
  logic          ovm_q, ovm_d, fault_q, fault_d;
  logic [2:0]    sec_q, sec_d;

  // Shadow takes S3 results; active set is swapped in only at the valley
  always_comb begin
    sh_t0_d  = sh_t0_q;
    sh_t1_d  = sh_t1_q;
    sh_t2_d  = sh_t2_q;
    sh_t7_d  = sh_t7_q;
    sh_ovm_d = sh_ovm_q;
    sh_sec_d = sh_sec_q;
    if (vld_s2_q) begin
      sh_t0_d  = t0c_c;
      sh_t1_d  = t1c_c;
      sh_t2_d  = t2c_c;
      sh_t7_d  = t7c_c;
      sh_ovm_d = ovmc_c;
      sh_sec_d = sec_s2_q;
    end
    t0_d    = t0_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t7_d    = t7_q;
    ovm_d   = ovm_q;
    fault_d = fault_q;
    sec_d   = sec_q;
    if (valley_next_c) begin
      t0_d    = sh_t0_q;
      t1_d    = sh_t1_q;
      t2_d    = sh_t2_q;
      t7_d    = sh_t7_q;
      ovm_d   = sh_ovm_q;
      sec_d   = sh_sec_q;
      fault_d = !sector_valid(sh_sec_q);
    end
  end

  // Shadow and active registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_t0_q  <= T_HALF_V;
      sh_t1_q  <= '0;
      sh_t2_q  <= '0;
      sh_t7_q  <= '0;
      sh_ovm_q <= 1'b0;
      sh_sec_q <= SECTOR_1;
      t0_q     <= T_HALF_V;
      t1_q     <= '0;
      t2_q     <= '0;
      t7_q     <= '0;
      ovm_q    <= 1'b0;
      fault_q  <= 1'b0;
      sec_q    <= SECTOR_1;
    end else begin
      sh_t0_q  <= sh_t0_d;
      sh_t1_q  <= sh_t1_d;
      sh_t2_q  <= sh_t2_d;
      sh_t7_q  <= sh_t7_d;
      sh_ovm_q <= sh_ovm_d;
      sh_sec_q <= sh_sec_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      t7_q     <= t7_d;
      ovm_q    <= ovm_d;
      fault_q  <= fault_d;
      sec_q    <= sec_d;
    end
  end

  // ---------------- phase compare ----------------
  sector_roles_t roles_c;
  logic [TW-1:0] tf_c, thr_lead_c, thr_mid_c, thr_last_c;
  logic [2:0]    raw_c;
  logic          en_c;

  // Map lead/mid/last thresholds onto phases A/B/C; invalid sector holds all phases low
  always_comb begin
    roles_c    = sector_roles(sec_q);
    tf_c       = roles_c.odd ? t1_q : t2_q;
    thr_lead_c = t0_q;
    thr_mid_c  = t0_q + tf_c;
    thr_last_c = t0_q + t1_q + t2_q;
    raw_c      = '0;
    for (int unsigned i = 0; i < N_PH; i++) begin
      if (roles_c.valid) begin
        if (roles_c.lead == 2'(i))     raw_c[i] = (cnt_q >= thr_lead_c);
        else if (roles_c.mid == 2'(i)) raw_c[i] = (cnt_q >= thr_mid_c);
        else                           raw_c[i] = (cnt_q >= thr_last_c);
      end
    end
  end

  assign en_c = enable && gate_en_q;

  for (genvar g = 0; g < 3; g++) begin : g_phase
    ac_motor_svpwm_gen_dead_time #(
      .DEADTIME (DEADTIME)
    ) u_dead_time (
      .clk     (clk),
      .reset   (reset),
      .en      (en_c),
      .raw     (raw_c[g]),
      .gate_hi (gate_hi[g]),
      .gate_lo (gate_lo[g])
    );
  end

  assign t0           = t0_q;
  assign t1           = t1_q;
  assign t2           = t2_q;
  assign t7           = t7_q;
  assign period_start = ps_q;
  assign ovm          = ovm_q;
  assign sector_fault = fault_q;

endmodule

// File: tb/tb_ac_motor_svpwm_gen.sv
// Directed bench for ac_motor_svpwm_gen, scaled to T_HALF=100 and DEADTIME=5 to keep runs short.
module tb_ac_motor_svpwm_gen;

  localparam int unsigned W      = 12;
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned PWM_HZ = 5_000;
  localparam int unsigned DT     = 5;
  localparam int unsigned TH     = 100;
  localparam int unsigned TW     = 7;
  localparam int unsigned PER    = 2 * TH;

  // Role table: lead/mid/last phase index (A=0,B=1,C=2) for sectors 1..6
  localparam int LEAD [6] = '{0, 1, 1, 2, 2, 0};
  localparam int MID  [6] = '{1, 0, 2, 1, 0, 2};

  logic          clk, reset, enable;
  logic [W-1:0]  u_str, sine_pos, sine_neg;
  logic [2:0]    sector;
  logic [TW-1:0] t0, t1, t2, t7;
  logic [2:0]    gate_hi, gate_lo;
  logic          period_start, ovm, sector_fault;

  ac_motor_svpwm_gen #(
    .W        (W),
    .CLK_HZ   (CLK_HZ),
    .PWM_HZ   (PWM_HZ),
    .DEADTIME (DT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .u_str        (u_str),
    .sine_pos     (sine_pos),
    .sine_neg     (sine_neg),
    .sector       (sector),
    .t0           (t0),
    .t1           (t1),
    .t2           (t2),
    .t7           (t7),
    .gate_hi      (gate_hi),
    .gate_lo      (gate_lo),
    .period_start (period_start),
    .ovm          (ovm),
    .sector_fault (sector_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int u, input int sp, input int sn, input int sec);
    u_str    = W'(u);
    sine_pos = W'(sp);
    sine_neg = W'(sn);
    sector   = 3'(sec);
  endtask

  // Advance to the next valley cycle; n returns the number of cycles taken
  task automatic wait_valley(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * PER && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (period_start) found = 1'b1;
    end
    check("valley_seen", int'(found), 1);
  endtask

  task automatic check_times(input string tag, input int e0, input int e1, input int e2, input int e7);
    check({tag, "_t0"}, int'(t0), e0);
    check({tag, "_t1"}, int'(t1), e1);
    check({tag, "_t2"}, int'(t2), e2);
    check({tag, "_t7"}, int'(t7), e7);
  endtask

  // Continuous monitor: time sum, gate overlap, off->on gaps, period spacing
  int         sum_err = 0, ovl_err = 0, gap_err = 0, per_err = 0, ps_seen = 0;
  int         run [3] = '{0, 0, 0};
  logic [2:0] hi_prev = '0, lo_prev = '0;
  int         since = 0;
  bit         armed = 1'b0;

  always @(negedge clk) begin
    if (int'(t0) + int'(t1) + int'(t2) + int'(t7) != TH) sum_err++;
    if ((gate_hi & gate_lo) != 3'b000) ovl_err++;
    for (int i = 0; i < 3; i++) begin
      if (((gate_hi[i] && !hi_prev[i]) || (gate_lo[i] && !lo_prev[i])) && run[i] < DT) gap_err++;
      run[i] = (gate_hi[i] || gate_lo[i]) ? 0 : run[i] + 1;
    end
    hi_prev = gate_hi;
    lo_prev = gate_lo;
    if (reset) begin
      armed = 1'b0;
      since = 0;
    end else begin
      since++;
      if (period_start) begin
        ps_seen++;
        if (armed && since != PER) per_err++;
        armed = 1'b1;
        since = 0;
      end
    end
  end

  initial begin
    int n;
    int pa, pb, exp_a;
    reset  = 1'b1;
    enable = 1'b1;
    set_in(0, 0, 0, 1);
    step(3);
    reset = 1'b0;

    // Zero magnitude: all zero time in t0/t7, coincident edges at cnt 50
    wait_valley(n);
    check_times("zero", 50, 0, 0, 50);
    check("zero_ovm", int'(ovm), 0);
    check("zero_fault", int'(sector_fault), 0);
    step(48);
    check("zero_hi_pre", int'(gate_hi), 0);
    check("zero_lo_pre", int'(gate_lo), 7);
    step(9);
    check("zero_hi_post", int'(gate_hi), 7);
    check("zero_lo_post", int'(gate_lo), 0);

    // Mid-period reset
    step(20);
    reset = 1'b1;
    step(5);
    check_times("rst", TH, 0, 0, 0);
    check("rst_hi", int'(gate_hi), 0);
    check("rst_lo", int'(gate_lo), 0);
    check("rst_ovm", int'(ovm), 0);
    check("rst_fault", int'(sector_fault), 0);
    check("rst_ps", int'(period_start), 0);
    set_in(4095, 0, 2048, 1);
    reset = 1'b0;
    wait_valley(n);
    check("rst_cnt_phase", n, PER);

    // Half-scale t1, no clamp
    check_times("half", 25, 49, 0, 26);
    check("half_ovm", int'(ovm), 0);

    // Full scale on both: overmodulation clamp
    set_in(4095, 4095, 4095, 1);
    wait_valley(n);
    check_times("ovm", 0, 99, 1, 0);
    check("ovm_flag", int'(ovm), 1);

    // Sector sweep: t0=19 t1=49 t2=12 t7=20
    for (int s = 1; s <= 6; s++) begin
      set_in(2048, 1000, 4095, s);
      wait_valley(n);
      if (s == 1) begin
        check_times("sweep", 19, 49, 12, 20);
        check("sweep_ovm", int'(ovm), 0);
        check("sweep_fault", int'(sector_fault), 0);
      end
      pa = (s % 2 == 1) ? 50 : 26;
      pb = (s % 2 == 1) ? 76 : 40;
      exp_a = 1 << LEAD[s-1];
      step(pa);
      check($sformatf("s%0d_lead_hi", s), int'(gate_hi), exp_a);
      check($sformatf("s%0d_lead_lo", s), int'(gate_lo), 7 ^ exp_a);
      step(pb - pa);
      check($sformatf("s%0d_mid_hi", s), int'(gate_hi), exp_a | (1 << MID[s-1]));
    end

    // Invalid sector: gates low-side only, fault flagged, times still updated
    set_in(4095, 0, 2048, 0);
    wait_valley(n);
    check("inv_fault", int'(sector_fault), 1);
    check("inv_t1", int'(t1), 49);
    step(60);
    set_in(2048, 1000, 4095, 1);
    step(40);
    check("inv_hi", int'(gate_hi), 0);
    check("inv_lo", int'(gate_lo), 7);

    // Enable drop and valley re-arm
    wait_valley(n);
    check("en_fault_clr", int'(sector_fault), 0);
    step(50);
    check("en_hi_on", int'(gate_hi), 1);
    enable = 1'b0;
    step(1);
    check("dis_hi", int'(gate_hi), 0);
    check("dis_lo", int'(gate_lo), 0);
    enable = 1'b1;
    step(10);
    check("rearm_hi", int'(gate_hi), 0);
    check("rearm_lo", int'(gate_lo), 0);
    wait_valley(n);
    check("valley_lo", int'(gate_lo), 0);
    step(10);
    check("resume_lo", int'(gate_lo), 7);
    check("resume_hi", int'(gate_hi), 0);
    step(40);
    check("resume_hi2", int'(gate_hi), 1);
    check("resume_lo2", int'(gate_lo), 6);

    step(5);
    check("mon_sum", sum_err, 0);
    check("mon_overlap", ovl_err, 0);
    check("mon_gap", gap_err, 0);
    check("mon_period", per_err, 0);
    check("mon_ps_seen", int'(ps_seen >= 10), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
